// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch front end. Owns the fetch PC, issues single-word reads to
// instruction memory over a request/response handshake (at most one request
// outstanding), buffers the returned words with their PCs in a small FIFO, and
// presents the FIFO head to decode over a valid/ready handshake. A redirect
// from downstream flushes the FIFO and restarts fetch at the new target. A
// request that is already in flight cannot be aborted, so its response is
// discarded.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears all state
//   imem_req     read request to instruction memory (registered)
//   imem_addr    word-aligned read address, stable while imem_req=1 (registered)
//   imem_rvalid  read data valid; completes the outstanding request
//   imem_rdata   returned instruction word
//   redirect     one-cycle pulse: taken branch/jump from downstream
//   redirect_pc  redirect target; bits [1:0] are ignored
//   id_valid     FIFO head holds an instruction
//   id_ready     decode accepts the head this cycle
//   id_instr     head instruction word
//   id_pc        PC of the head instruction
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [31:0]         id_instr,
  output logic [PC_WIDTH-1:0] id_pc
);

  localparam int                  AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                  CW        = AW + 1;
  localparam logic [CW-1:0]       DEPTH_C   = CW'(DEPTH);
  localparam logic [PC_WIDTH-1:0] WORD_MASK = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0] PC_STEP   = PC_WIDTH'(4);

  // IDLE:   nothing outstanding
  // FETCH:  request outstanding, its data will be enqueued
  // SQUASH: request outstanding, its data will be dropped (wrong path)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                req_d;
  logic [PC_WIDTH-1:0] addr_d;

  logic [31:0]         fifo_instr [DEPTH];
  logic [PC_WIDTH-1:0] fifo_pc    [DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count_q, count_d;

  logic outstanding;
  logic enq;
  logic deq;

  // Decode sees the head registers directly; no bypass from imem_rdata.
  assign id_valid = (count_q != '0);
  assign id_instr = fifo_instr[rd_ptr];
  assign id_pc    = fifo_pc[rd_ptr];

  assign outstanding = (state_q != IDLE);
  // A response arriving in IDLE is stale (e.g. from before reset) and ignored;
  // one arriving in SQUASH or alongside a redirect is wrong-path and dropped.
  assign enq = (state_q == FETCH) && imem_rvalid && !redirect;
  // Redirect wins over a same-cycle pop; that pop does not happen.
  assign deq = id_valid && id_ready && !redirect;

  // Next-state, next-PC and request logic.
  // fetch_pc doubles as the stored redirect target while squashing: a newer
  // redirect simply overwrites it, and the squashed request keeps its own
  // address in imem_addr until its response arrives.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d    = state_q;
    req_d      = imem_req;
    addr_d     = imem_addr;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;

    if (redirect) begin
      count_d    = '0;
      fetch_pc_d = redirect_pc & WORD_MASK;
    end else begin
      count_d = count_q + CW'(enq) - CW'(deq);
      if (enq) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
    end

    if (outstanding && !imem_rvalid) begin
      // Request still in flight: hold it; a redirect turns it into a squash.
      if (redirect) begin
        state_d = SQUASH;
      end
    end else if (count_d < DEPTH_C) begin
      // Nothing outstanding after this edge and a slot is free for the reply.
      state_d = FETCH;
      req_d   = 1'b1;
      addr_d  = fetch_pc_d;
    end else begin
      state_d = IDLE;
      req_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      imem_req   <= req_d;
      imem_addr  <= addr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the FIFO storage is reset deliberately: id_instr/id_pc read it
      // directly and must show zero out of reset.
      fifo_instr <= '{default: '0};
      fifo_pc    <= '{default: '0};
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) begin
        fifo_instr[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]    <= fetch_pc_q;
        wr_ptr             <= wr_ptr + AW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Bench for if_fetch_queue (default parameters: 64-bit PC, RESET_PC=0,
// DEPTH=2). A behavioural instruction memory answers each request after a
// programmable latency with a word derived from its address. Directed
// cycle-by-cycle vectors cover reset, fill/stall/drain and the fetch rate;
// hand-written sequences cover redirect corner cases, PC wrap and a stale
// response after reset; a random phase compares the delivered instruction
// stream against the rule "PCs run sequentially from the last redirect target".
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;

  int checks   = 0;
  int failures = 0;

  if_fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- instruction memory model ----------------
  int          mem_lat      = 1;
  logic        mem_busy     = 1'b0;
  int          mem_cnt      = 0;
  logic [63:0] mem_addr     = 64'h0;
  logic        stale_inject = 1'b0;
  int          mem_err      = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (imem_rvalid) begin
        imem_rvalid = 1'b0;
        mem_busy    = 1'b0;
      end
      if (stale_inject) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
      end else if (reset) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        if (!imem_req || imem_addr != mem_addr) mem_err++;
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word_of(mem_addr);
        end
      end else if (imem_req) begin
        if (imem_addr[1:0] != 2'b00) mem_err++;
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = mem_lat;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    id_ready    = 1'b0;
    step();
    step();
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, 64'h0);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc", id_pc, 64'h0);
    reset = 1'b0;
  endtask

  task automatic wait_addr(input string name, input logic [63:0] addr, input bit no_valid);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (no_valid) check({name, "_no_stale"}, id_valid, 1'b0);
      if (imem_req && imem_addr == addr) found = 1'b1;
    end
    check({name, "_addr_seen"}, found, 1'b1);
  endtask

  task automatic wait_deliver(input string name, input logic [63:0] exp_pc);
    bit got = 1'b0;
    id_ready = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (id_valid) begin
        check({name, "_pc"}, id_pc, exp_pc);
        check({name, "_instr"}, id_instr, word_of(exp_pc));
        got = 1'b1;
      end
    end
    check({name, "_delivered"}, got, 1'b1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t tbl [13];

  logic [63:0] exp_pc;
  logic [63:0] rpc;
  int          deliveries;
  bit          prev_redir;
  bit          seen;

  initial begin
    // Row r: outputs expected after the (r+1)-th edge past reset release,
    // then id_ready driven for the following edge. Memory latency 1.
    tbl[0]  = '{1'b0, 1'b1, 64'h0,  1'b0, 64'h0};
    tbl[1]  = '{1'b0, 1'b1, 64'h0,  1'b0, 64'h0};
    tbl[2]  = '{1'b0, 1'b1, 64'h4,  1'b1, 64'h0};
    tbl[3]  = '{1'b0, 1'b1, 64'h4,  1'b1, 64'h0};
    tbl[4]  = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h0};   // FIFO full: no request
    tbl[5]  = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h0};
    tbl[6]  = '{1'b1, 1'b1, 64'h8,  1'b1, 64'h4};   // pop frees credit
    tbl[7]  = '{1'b1, 1'b1, 64'h8,  1'b0, 64'h0};
    tbl[8]  = '{1'b1, 1'b1, 64'hC,  1'b1, 64'h8};
    tbl[9]  = '{1'b1, 1'b1, 64'hC,  1'b0, 64'h0};
    tbl[10] = '{1'b1, 1'b1, 64'h10, 1'b1, 64'hC};
    tbl[11] = '{1'b1, 1'b1, 64'h10, 1'b0, 64'h0};
    tbl[12] = '{1'b1, 1'b1, 64'h14, 1'b1, 64'h10};

    mem_lat = 1;
    do_reset();
    for (int r = 0; r < 13; r++) begin
      step();
      check($sformatf("tbl%0d_req", r), imem_req, tbl[r].exp_req);
      if (tbl[r].exp_req) check($sformatf("tbl%0d_addr", r), imem_addr, tbl[r].exp_addr);
      check($sformatf("tbl%0d_valid", r), id_valid, tbl[r].exp_valid);
      if (tbl[r].exp_valid) begin
        check($sformatf("tbl%0d_pc", r), id_pc, tbl[r].exp_pc);
        check($sformatf("tbl%0d_instr", r), id_instr, word_of(tbl[r].exp_pc));
      end
      id_ready = tbl[r].ready;
    end

    // A: redirect to 0x103 while the 0x8 request is outstanding (latency 3).
    mem_lat = 3;
    do_reset();
    id_ready = 1'b1;
    wait_addr("A_pre", 64'h8, 1'b0);
    redirect    = 1'b1;
    redirect_pc = 64'h103;
    step();
    redirect = 1'b0;
    check("A_flush_valid", id_valid, 1'b0);
    check("A_hold_req", imem_req, 1'b1);
    check("A_hold_addr", imem_addr, 64'h8);
    wait_addr("A_target", 64'h100, 1'b1);
    wait_deliver("A_first", 64'h100);

    // B: redirect together with rvalid, then redirects into and during SQUASH.
    mem_lat = 3;
    do_reset();
    id_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = imem_rvalid;
    end
    check("B_rvalid_seen", seen, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    step();
    check("B_same_req", imem_req, 1'b1);
    check("B_same_addr", imem_addr, 64'h200);
    check("B_same_valid", id_valid, 1'b0);
    redirect_pc = 64'h300;
    step();
    check("B_squash_addr", imem_addr, 64'h200);
    check("B_squash_valid", id_valid, 1'b0);
    redirect_pc = 64'h405;
    step();
    redirect = 1'b0;
    wait_addr("B_target", 64'h404, 1'b1);
    wait_deliver("B_first", 64'h404);
    wait_deliver("B_second", 64'h408);

    // C: fetch PC wraps from the top of the address space to 0.
    mem_lat = 1;
    do_reset();
    id_ready = 1'b1;
    step();
    step();
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    redirect = 1'b0;
    check("C_flush_valid", id_valid, 1'b0);
    wait_deliver("C_top", 64'hFFFF_FFFF_FFFF_FFFC);
    wait_deliver("C_wrap", 64'h0);
    wait_deliver("C_next", 64'h4);

    // D: async reset mid-request, then a stale response right after release.
    mem_lat = 3;
    do_reset();
    wait_deliver("D_pre0", 64'h0);
    wait_addr("D_pre", 64'h4, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("D_async_req", imem_req, 1'b0);
    check("D_async_addr", imem_addr, 64'h0);
    check("D_async_valid", id_valid, 1'b0);
    step();
    stale_inject = 1'b1;
    step();
    stale_inject = 1'b0;
    reset        = 1'b0;
    step();
    check("D_first_req", imem_req, 1'b1);
    check("D_first_addr", imem_addr, 64'h0);
    check("D_stale_ignored", id_valid, 1'b0);
    wait_deliver("D_first", 64'h0);

    // Random phase: delivered PCs must run sequentially from the last target.
    mem_lat = 1;
    do_reset();
    exp_pc     = 64'h0;
    deliveries = 0;
    prev_redir = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      mem_lat = $urandom_range(1, 4);
      if (prev_redir) check("rnd_flush", id_valid, 1'b0);
      if (id_valid) begin
        check("rnd_head_pc", id_pc, exp_pc);
        check("rnd_head_instr", id_instr, word_of(exp_pc));
      end
      id_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      if (id_valid && id_ready && !redirect) begin
        exp_pc = exp_pc + 64'd4;
        deliveries++;
      end
      if (redirect) begin
        if ($urandom_range(0, 3) == 0)
          rpc = {32'hFFFF_FFFF, 24'hFF_FFFF, 8'($urandom_range(0, 255))};
        else
          rpc = {48'h0, 16'($urandom)};
        redirect_pc = rpc;
        exp_pc      = rpc & ~64'd3;
      end
      prev_redir = redirect;
    end
    redirect = 1'b0;
    check("rnd_throughput", (deliveries >= 200), 1'b1);
    check("mem_protocol_errors", mem_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
